// File: rtl/aes_round_sched.sv
// aes_round_sched: control sequencer for an iterative AES encryption datapath.
// Per block it accepts one job, steps key expansion one word per cycle,
// issues the initial AddRoundKey, runs rounds 1..Nr, and then holds the
// result valid until the consumer takes it. Only strobes and indices are
// produced here. The state register, round logic and key RAM are external.
module aes_round_sched #(
  parameter int unsigned Nb = 4,
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       load_en,
  output logic       kexp_en,
  output logic [5:0] kexp_idx,
  output logic       kexp_rot,
  output logic       kexp_sub,
  output logic [3:0] kexp_rcon,
  output logic       ark_en,
  output logic       rnd_en,
  output logic [3:0] rnd_num,
  output logic       rnd_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  // Only AES-128/192/256 geometries are meaningful.
  if (Nb != 4 || !(Nk == 4 || Nk == 6 || Nk == 8) || Nr != Nk + 6) begin : g_bad_geometry
    $error("aes_round_sched: illegal Nb/Nk/Nr combination");
  end

  localparam int unsigned NWORDS = Nb * (Nr + 1);
  localparam logic [5:0]  I_FIRST = 6'(Nk);
  localparam logic [5:0]  I_LAST  = 6'(NWORDS - 1);
  localparam logic [2:0]  MOD_TOP = 3'(Nk - 1);
  localparam logic [3:0]  RND_TOP = 4'(Nr);
  localparam bit          SUB_MID = (Nk > 6);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEXP,
    S_INIT,
    S_ROUND,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] i_q, i_d;
  logic [2:0] imod_q, imod_d;
  logic [3:0] rcon_q, rcon_d;
  logic [3:0] rnd_q, rnd_d;
  logic       hand_q, hand_d;

  // State and counter registers. Reset aborts any job in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      imod_q  <= '0;
      rcon_q  <= '0;
      rnd_q   <= '0;
      hand_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      imod_q  <= imod_d;
      rcon_q  <= rcon_d;
      rnd_q   <= rnd_d;
      hand_q  <= hand_d;
    end
  end

  // Next-state logic and counter sequencing.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    imod_d  = imod_q;
    rcon_d  = rcon_q;
    rnd_d   = rnd_q;
    hand_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !hand_q) begin
          state_d = S_KEXP;
          i_d     = I_FIRST;
          imod_d  = '0;
          rcon_d  = 4'd1;
        end
      end
      S_KEXP: begin
        if (i_q == I_LAST) begin
          state_d = S_INIT;
          i_d     = '0;
          imod_d  = '0;
          rcon_d  = '0;
        end else begin
          i_d = i_q + 6'd1;
          // Track i mod Nk with a wrapping counter. Rcon advances on each wrap.
          if (imod_q == MOD_TOP) begin
            imod_d = '0;
            rcon_d = rcon_q + 4'd1;
          end else begin
            imod_d = imod_q + 3'd1;
          end
        end
      end
      S_INIT: begin
        state_d = S_ROUND;
        rnd_d   = 4'd1;
      end
      S_ROUND: begin
        if (rnd_q == RND_TOP) begin
          state_d = S_DONE;
          rnd_d   = '0;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          hand_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decode outputs from the registered state. Strobed fields are zero outside
  // their own phase. hand_q blocks acceptance for the single idle cycle after
  // a result handshake, which gives a back-to-back period of latency + 2.
  always_comb begin
    in_ready  = 1'b0;
    load_en   = 1'b0;
    kexp_en   = 1'b0;
    kexp_idx  = '0;
    kexp_rot  = 1'b0;
    kexp_sub  = 1'b0;
    kexp_rcon = '0;
    ark_en    = 1'b0;
    rnd_en    = 1'b0;
    rnd_num   = '0;
    rnd_last  = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        in_ready = !hand_q;
        load_en  = in_valid && !hand_q;
      end
      S_KEXP: begin
        kexp_en  = 1'b1;
        kexp_idx = i_q;
        kexp_rot = (imod_q == 3'd0);
        kexp_sub = (imod_q == 3'd0) || (SUB_MID && imod_q == 3'd4);
        if (imod_q == 3'd0) kexp_rcon = rcon_q;
      end
      S_INIT: begin
        ark_en = 1'b1;
      end
      S_ROUND: begin
        rnd_en   = 1'b1;
        rnd_num  = rnd_q;
        rnd_last = (rnd_q == RND_TOP);
      end
      S_DONE: begin
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
